// File: rtl/wac_com_ctrl_pkg.sv
// rtl/wac_com_ctrl_pkg.sv - shared constants and types for the WAC communication controller
//
// Purpose: EPP register addresses, ctrlWord bit positions and the
// acquisition FSM state encoding. The state codes are visible on stTest.
// Ports: none (package).

package wac_com_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_CONF = 2'd1;
  localparam logic [1:0] ADDR_NSMP = 2'd2;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_WR_HI = 3'd2,
    ST_WR_LO = 3'd3,
    ST_DONE  = 3'd4
  } acqStateT;

endpackage

// File: rtl/epp_strobe_sync.sv
// rtl/epp_strobe_sync.sv - two-stage capture of the EPP strobe bus and write-pulse generation
//
// Purpose: registers {dataStb, addrEpp, busBramIn} through an identical
// two-stage pipeline and flags a write when the second strobe stage
// falls from 1 to 0.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   dataStb         - EPP data strobe, active-low, asynchronous
//   addrEpp         - register select
//   busBramIn       - write data byte
//   wrEn            - one-cycle write pulse
//   wrAddr, wrData  - address and data of the write (second stage)

module epp_strobe_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       dataStb,
  input  logic [1:0] addrEpp,
  input  logic [7:0] busBramIn,
  output logic       wrEn,
  output logic [1:0] wrAddr,
  output logic [7:0] wrData
);

  logic       stb1, stb2, stb2Prev;
  logic [1:0] addr1, addr2;
  logic [7:0] data1, data2;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Strobe is idle-high, so the pipeline resets to 1 to avoid a
      // spurious write as reset is released.
      stb1     <= 1'b1;
      stb2     <= 1'b1;
      stb2Prev <= 1'b1;
      addr1    <= '0;
      addr2    <= '0;
      data1    <= '0;
      data2    <= '0;
    end else begin
      stb1     <= dataStb;
      stb2     <= stb1;
      stb2Prev <= stb2;
      addr1    <= addrEpp;
      addr2    <= addr1;
      data1    <= busBramIn;
      data2    <= data1;
    end
  end

  // Falling edge of the second stage; address/data travel alongside the
  // strobe so they are aligned with this pulse.
  assign wrEn   = stb2Prev & ~stb2;
  assign wrAddr = addr2;
  assign wrData = data2;

endmodule

// File: rtl/wac_com_ctrl.sv
// rtl/wac_com_ctrl.sv - WAC host register decode and ADC-to-BRAM acquisition controller
//
// Purpose: decodes EPP byte writes into ctrlWord/confWord/nSamples and,
// when armed, stores nSamples 12-bit ADC samples into an 8-bit BRAM as
// two bytes each (high nibble first).
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   dataStb/addrEpp/busBramIn - EPP write strobe, register select, data
//   datoAdc, readyAdc     - ADC sample and its one-cycle valid pulse
//   busBramAddr/busBramOut/ctrlWeBram/clkBram - BRAM write port
//   ctrlWord/confWord/nSamples - host registers
//   busy, contData, controlEn, modeAdc, stTest - status and debug

module wac_com_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        dataStb,
  input  logic [1:0]  addrEpp,
  input  logic [7:0]  busBramIn,
  input  logic [11:0] datoAdc,
  input  logic        readyAdc,
  output logic [11:0] busBramAddr,
  output logic [7:0]  busBramOut,
  output logic        ctrlWeBram,
  output logic        clkBram,
  output logic [7:0]  ctrlWord,
  output logic [15:0] confWord,
  output logic [11:0] nSamples,
  output logic        busy,
  output logic [2:0]  contData,
  output logic        controlEn,
  output logic        modeAdc,
  output logic [2:0]  stTest
);

  import wac_com_ctrl_pkg::*;

  logic       wrEn;
  logic [1:0] wrAddr;
  logic [7:0] wrData;

  acqStateT    state, stateNext;
  logic [11:0] addrNext;
  logic [11:0] sampleCnt, sampleCntNext;
  logic [11:0] sample, sampleNext;
  logic [11:0] sampleCntInc;

  epp_strobe_sync uStrobe (
    .clk       (clk),
    .rst       (rst),
    .dataStb   (dataStb),
    .addrEpp   (addrEpp),
    .busBramIn (busBramIn),
    .wrEn      (wrEn),
    .wrAddr    (wrAddr),
    .wrData    (wrData)
  );

  assign clkBram   = clk;
  assign controlEn = ctrlWord[CTRL_EN];
  assign modeAdc   = ctrlWord[CTRL_MODE];
  assign stTest    = state;

  // Host register file; writes are accepted regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlWord <= '0;
      confWord <= '0;
      nSamples <= '0;
      contData <= '0;
    end else if (wrEn) begin
      case (wrAddr)
        ADDR_CTRL: ctrlWord <= wrData;
        ADDR_CONF: confWord <= {confWord[7:0], wrData};
        ADDR_NSMP: nSamples <= {nSamples[3:0], wrData};
        default:   ;
      endcase
      contData <= contData + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busBramAddr <= '0;
      sampleCnt   <= '0;
      sample      <= '0;
    end else begin
      state       <= stateNext;
      busBramAddr <= addrNext;
      sampleCnt   <= sampleCntNext;
      sample      <= sampleNext;
    end
  end

  assign sampleCntInc = sampleCnt + 12'd1;

  always_comb begin
    stateNext     = state;
    addrNext      = busBramAddr;
    sampleCntNext = sampleCnt;
    sampleNext    = sample;
    busy          = 1'b0;
    ctrlWeBram    = 1'b0;
    busBramOut    = '0;
    case (state)
      ST_IDLE: begin
        if (controlEn && (nSamples != 12'd0)) begin
          addrNext      = '0;
          sampleCntNext = '0;
          stateNext     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        // Abort wins over a coincident sample.
        if (!controlEn) begin
          stateNext = ST_IDLE;
        end else if (readyAdc) begin
          sampleNext = datoAdc;
          stateNext  = ST_WR_HI;
        end
      end
      ST_WR_HI: begin
        busy       = 1'b1;
        ctrlWeBram = 1'b1;
        busBramOut = {4'h0, sample[11:8]};
        addrNext   = busBramAddr + 12'd1;
        stateNext  = ST_WR_LO;
      end
      ST_WR_LO: begin
        busy          = 1'b1;
        ctrlWeBram    = 1'b1;
        busBramOut    = sample[7:0];
        addrNext      = busBramAddr + 12'd1;
        sampleCntNext = sampleCntInc;
        // Compared against the live nSamples so host updates mid-run apply.
        stateNext     = (sampleCntInc == nSamples) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: begin
        if (!controlEn) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wac_com_ctrl.sv
// tb/tb_wac_com_ctrl.sv - directed self-checking bench for wac_com_ctrl

module tb_wac_com_ctrl;

  logic        clk;
  logic        rst;
  logic        dataStb;
  logic [1:0]  addrEpp;
  logic [7:0]  busBramIn;
  logic [11:0] datoAdc;
  logic        readyAdc;
  logic [11:0] busBramAddr;
  logic [7:0]  busBramOut;
  logic        ctrlWeBram;
  logic        clkBram;
  logic [7:0]  ctrlWord;
  logic [15:0] confWord;
  logic [11:0] nSamples;
  logic        busy;
  logic [2:0]  contData;
  logic        controlEn;
  logic        modeAdc;
  logic [2:0]  stTest;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:4095];
  int         byteCount = 0;
  int         base;

  wac_com_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .dataStb     (dataStb),
    .addrEpp     (addrEpp),
    .busBramIn   (busBramIn),
    .datoAdc     (datoAdc),
    .readyAdc    (readyAdc),
    .busBramAddr (busBramAddr),
    .busBramOut  (busBramOut),
    .ctrlWeBram  (ctrlWeBram),
    .clkBram     (clkBram),
    .ctrlWord    (ctrlWord),
    .confWord    (confWord),
    .nSamples    (nSamples),
    .busy        (busy),
    .contData    (contData),
    .controlEn   (controlEn),
    .modeAdc     (modeAdc),
    .stTest      (stTest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: write-enable is held for a full cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (ctrlWeBram === 1'b1) begin
      mem[busBramAddr] <= busBramOut;
      byteCount        <= byteCount + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic eppWrite(input logic [1:0] a, input logic [7:0] d);
    addrEpp   = a;
    busBramIn = d;
    dataStb   = 1'b0;
    tick(2);
    dataStb   = 1'b1;
    tick(2);
  endtask

  task automatic waitState(input string tag, input logic [2:0] exp);
    int n = 0;
    while (stTest !== exp && n < 50) begin
      tick(1);
      n++;
    end
    check(tag, {29'd0, stTest}, {29'd0, exp});
  endtask

  // Sample in WAIT, then keep readyAdc high with junk through WR_HI/WR_LO.
  task automatic sampleWithJunk(input logic [11:0] s);
    readyAdc = 1'b1;
    datoAdc  = s;
    tick(1);
    datoAdc  = 12'hABC;
    tick(2);
    readyAdc = 1'b0;
    datoAdc  = 12'h000;
    tick(1);
  endtask

  initial begin
    rst       = 1'b1;
    dataStb   = 1'b1;
    addrEpp   = 2'd0;
    busBramIn = 8'h00;
    datoAdc   = 12'h000;
    readyAdc  = 1'b0;
    tick(3);
    check("rst_stTest", {29'd0, stTest}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_regs", {ctrlWord, confWord, 8'd0}, 32'd0);
    check("rst_we", {31'd0, ctrlWeBram}, 32'd0);
    rst = 1'b0;
    tick(2);

    eppWrite(2'd0, 8'h55);
    eppWrite(2'd1, 8'h59);
    eppWrite(2'd1, 8'h10);
    check("ctrlWord", {24'd0, ctrlWord}, 32'h55);
    check("confWord", {16'd0, confWord}, 32'h5910);
    check("contData3", {29'd0, contData}, 32'd3);
    check("en_mode", {30'd0, controlEn, modeAdc}, 32'b10);
    check("nsmp0_idle", {29'd0, stTest}, 32'd0);

    eppWrite(2'd2, 8'h01);
    eppWrite(2'd2, 8'hE8);
    check("nSamples1E8", {20'd0, nSamples}, 32'h1E8);
    eppWrite(2'd3, 8'hAA);
    check("addr3_regs", {ctrlWord, confWord, 8'd0}, 32'h55591000);
    check("addr3_nsmp", {20'd0, nSamples}, 32'h1E8);
    check("contData6", {29'd0, contData}, 32'd6);
    check("armed_busy", {31'd0, busy}, 32'd1);
    eppWrite(2'd0, 8'h00);
    check("abort_st", {29'd0, stTest}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);

    eppWrite(2'd2, 8'h00);
    eppWrite(2'd2, 8'h02);
    check("nSamples2", {20'd0, nSamples}, 32'd2);
    check("contData_wrap", {29'd0, contData}, 32'd1);

    base = byteCount;
    eppWrite(2'd0, 8'h01);
    waitState("run_wait", 3'd1);
    check("run_busy", {31'd0, busy}, 32'd1);
    sampleWithJunk(12'h144);
    check("ignored_cnt", byteCount - base, 32'd2);
    check("after1_st", {29'd0, stTest}, 32'd1);
    tick(3);
    readyAdc = 1'b1;
    datoAdc  = 12'h147;
    tick(1);
    readyAdc = 1'b0;
    tick(2);
    check("done_st", {29'd0, stTest}, 32'd4);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("bytes4", byteCount - base, 32'd4);
    check("bram0_3", {mem[0], mem[1], mem[2], mem[3]}, 32'h01440147);
    check("addr4", {20'd0, busBramAddr}, 32'd4);

    eppWrite(2'd0, 8'h00);
    check("done_idle", {29'd0, stTest}, 32'd0);
    base = byteCount;
    eppWrite(2'd0, 8'h03);
    check("mode", {30'd0, controlEn, modeAdc}, 32'b11);
    waitState("rearm_wait", 3'd1);
    check("rearm_addr", {20'd0, busBramAddr}, 32'd0);
    sampleWithJunk(12'hFFF);
    check("rearm_bytes", {16'd0, mem[0], mem[1]}, 32'h0FFF);
    check("rearm_cnt", byteCount - base, 32'd2);

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("mrst_st", {29'd0, stTest}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_regs", {ctrlWord, confWord, 8'd0}, 32'd0);
    check("mrst_misc", {nSamples, busBramAddr, 5'd0, contData}, 32'd0);
    base = byteCount;
    readyAdc = 1'b1;
    datoAdc  = 12'h123;
    tick(1);
    readyAdc = 1'b0;
    tick(4);
    check("mrst_noWe", byteCount - base, 32'd0);
    check("mrst_out", {23'd0, ctrlWeBram, busBramOut}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wac_com_ctrl.md
# wac_com_ctrl

Host-side communication and acquisition controller for the WAC board. It decodes byte writes arriving over an EPP-style strobe/address interface into a control register, a configuration word and a sample count. When armed, it captures 12-bit ADC samples into an external 8-bit block RAM, two bytes per sample, and reports progress through `busy` and debug outputs. It sits between the EPP host front-end, the ADC driver and the sample BRAM.

## Interface
- No parameters. Fixed widths: BRAM address 12 b, data 8 b, ADC 12 b.
- `clk` in 1: single system clock; every register is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `dataStb` in 1: EPP data strobe, active-low, asynchronous to `clk`; each low pulse is one byte write.
- `addrEpp` in 2: register select for the write.
- `busBramIn` in 8: write data byte for the write.
- `datoAdc` in 12: ADC sample, valid while `readyAdc`=1.
- `readyAdc` in 1: one-cycle, synchronous sample-valid pulse.
- `busBramAddr` out 12: BRAM byte address.
- `busBramOut` out 8: BRAM write data.
- `ctrlWeBram` out 1: BRAM write enable, one cycle per byte.
- `clkBram` out 1: BRAM clock, equal to `clk` (pass-through).
- `ctrlWord` out 8: control register.
- `confWord` out 16: configuration register.
- `nSamples` out 12: samples per acquisition.
- `busy` out 1: acquisition in progress.
- `contData` out 3: count of accepted strobes, modulo 8.
- `controlEn` out 1: equals `ctrlWord[0]` (arm/start).
- `modeAdc` out 1: equals `ctrlWord[1]`.
- `stTest` out 3: current FSM state code.

## Operation
- **Strobe capture**
  - `dataStb`, `addrEpp` and `busBramIn` pass together through an identical two-stage register pipeline.
  - An accepted write occurs when the second stage of the strobe goes from 1 to 0. Address and data are taken from the second stage.
  - The low pulse must last at least one `clk` period.
- **Register writes**, by address:
  - 0: `ctrlWord` <= byte.
  - 1: `confWord` <= {`confWord[7:0]`, byte}. The first byte becomes the high byte.
  - 2: `nSamples` <= {`nSamples[3:0]`, byte}. Write the high nibble first, then the low byte.
  - 3: no effect other than incrementing `contData`.
- Every accepted write increments `contData`, which wraps from 7 to 0.
- **FSM** (`stTest` code in parentheses):
  - IDLE (0): `busy`=0. If `controlEn`=1 and `nSamples`≠0: `busBramAddr`<=0, sample counter<=0, go to WAIT.
  - WAIT (1): `busy`=1.
    - `controlEn`=0: go to IDLE (abort).
    - `readyAdc`=1: latch `datoAdc` and go to WR_HI.
  - WR_HI (2): drive `busBramOut`={4'h0, sample[11:8]} with `ctrlWeBram`=1. Address increments at the end of the state. Go to WR_LO.
  - WR_LO (3): drive `busBramOut`=sample[7:0] with `ctrlWeBram`=1. Address increments; sample counter increments. Go to DONE if the counter equals `nSamples`, otherwise to WAIT.
  - DONE (4): `busy`=0. Wait for `controlEn`=0, then go to IDLE.
- **Boundary rules**
  - `readyAdc` is ignored outside WAIT.
  - `busBramAddr` wraps modulo 4096.
  - Register writes remain accepted in every state. Changing `nSamples` mid-run takes effect at the next comparison.
  - `nSamples`=0 never starts an acquisition.
- **Reset**: all registers, counters and outputs go to 0, the FSM goes to IDLE, and the strobe pipeline is set to 1 (idle-high). Reset mid-acquisition abandons the run.

## Timing
- Write latency: registers update on the 3rd rising edge after `dataStb` is first sampled low. Writes are back-to-back capable when the strobe is high for at least 1 cycle.
- `readyAdc` pulse in WAIT: WR_HI on the next edge. Each sample costs 3 cycles minimum; one `readyAdc` per 3 cycles is the maximum rate.
- `busy` rises 1 cycle after `controlEn` is seen in IDLE. It falls on entry to DONE.
- `clkBram` is combinational from `clk`. BRAM samples address/data/WE on its rising edge.

## Structure
- Shared package: EPP address constants (CTRL=0, CONF=1, NSMP=2); FSM state enum (3-bit codes above); `ctrlWord` bit indices (EN=0, MODE=1).
- One natural sub-module: `epp_strobe_sync`. It holds the two-stage pipeline of {strobe, addr, data} and the falling-edge write pulse.

## Test plan
- Three strobes with addr 0/1/1 and data 0x55, 0x59, 0x10 -> `ctrlWord`=0x55, `confWord`=0x5910, `contData`=3, `controlEn`=1, `modeAdc`=0.
- Writes to addr 2 of 0x01 then 0xE8 -> `nSamples`=0x1E8; addr 3 write changes nothing except `contData`.
- `nSamples`=2, `ctrlWord`=0x01, `readyAdc` pulses with `datoAdc` 0x144 then 0x147 -> BRAM bytes 0x01,0x44,0x01,0x47 at addresses 0..3. `busy` drops after the 4th write; `stTest`=4.
- `ctrlWord`<=0x00 during WAIT -> IDLE, `busy`=0. Re-arm -> address restarts at 0.
- `readyAdc` pulses arriving in WR_HI/WR_LO -> ignored; byte count unchanged.
- Assert `rst` mid-run -> all outputs 0, `stTest`=0, no further `ctrlWeBram`.
